// File: rtl/imm_ext_pipe.sv
// Purpose: extends an IN_W-bit immediate to OUT_W bits (sign / zero / upper / branch) into a 2-entry FIFO.
// Latency: 1 cycle, push to visible at the head when the buffer is empty; 1 result per cycle while streaming.
// Backpressure: in_ready drops only when both entries are full and never depends on out_ready.
module imm_ext_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  imm,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [1:0]       out_mode,
  output logic [1:0]       occupancy
);

  localparam int PAD = OUT_W - IN_W;

  localparam logic [1:0] MODE_SIGN   = 2'b00;
  localparam logic [1:0] MODE_ZERO   = 2'b01;
  localparam logic [1:0] MODE_UPPER  = 2'b10;
  localparam logic [1:0] MODE_BRANCH = 2'b11;

  // Reject parameter sets the bit-slicing below cannot handle.
  generate
    if (IN_W < 2 || OUT_W < IN_W + 2 || DEPTH != 2) begin : g_bad_params
      $error("imm_ext_pipe: illegal parameters (need IN_W>=2, OUT_W>=IN_W+2, DEPTH==2)");
    end
  endgenerate

  // Entry 0 is always the head; entry 1 is only meaningful when occupancy is 2.
  logic [OUT_W-1:0] ent0_data, ent1_data;
  logic [1:0]       ent0_mode, ent1_mode;
  logic [1:0]       occ;

  logic [OUT_W-1:0] sign_val;
  logic [OUT_W-1:0] ext_val;
  logic             push, pop;

  // Extension happens before storage so the buffer holds finished results.
  always_comb begin
    sign_val = {{PAD{imm[IN_W-1]}}, imm};
    ext_val  = sign_val;
    case (mode)
      MODE_SIGN:   ext_val = sign_val;
      MODE_ZERO:   ext_val = {{PAD{1'b0}}, imm};
      MODE_UPPER:  ext_val = {imm, {PAD{1'b0}}};
      MODE_BRANCH: ext_val = {sign_val[OUT_W-3:0], 2'b00};
      default:     ext_val = sign_val;
    endcase
  end

  // Handshakes; in_ready looks only at registered occupancy, never at out_ready.
  always_comb begin
    in_ready  = ~rst & (occ != 2'd2);
    out_valid = (occ != 2'd0);
    push      = in_valid & in_ready;
    pop       = out_valid & out_ready & ~rst;
    out_data  = ent0_data;
    out_mode  = ent0_mode;
    occupancy = occ;
  end

  // Shift-style 2-entry buffer; when it empties, the head keeps the last popped value.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_data <= '0;
      ent0_mode <= '0;
      ent1_data <= '0;
      ent1_mode <= '0;
      occ       <= 2'd0;
    end else if (push && pop) begin
      // Only reachable with one entry held: the new entry replaces the head.
      ent0_data <= ext_val;
      ent0_mode <= mode;
    end else if (pop) begin
      if (occ == 2'd2) begin
        ent0_data <= ent1_data;
        ent0_mode <= ent1_mode;
      end
      occ <= occ - 2'd1;
    end else if (push) begin
      if (occ == 2'd0) begin
        ent0_data <= ext_val;
        ent0_mode <= mode;
      end else begin
        ent1_data <= ext_val;
        ent1_mode <= mode;
      end
      occ <= occ + 2'd1;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] imm = '0;
  logic [1:0]  mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [1:0]  out_mode;
  logic [1:0]  occupancy;

  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [7:0]  imm8 = '0;
  logic [1:0]  mode8 = '0;
  logic        out_valid8;
  logic [15:0] out_data8;
  logic [1:0]  out_mode8;
  logic [1:0]  occupancy8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  imm_ext_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .imm(imm), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_mode(out_mode), .occupancy(occupancy)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .DEPTH(2)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8), .imm(imm8), .mode(mode8),
    .out_valid(out_valid8), .out_ready(1'b1),
    .out_data(out_data8), .out_mode(out_mode8), .occupancy(occupancy8)
  );

  // Advance one edge; sample/drive 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h exp=00000000", out_data); end
    checks++; if (out_mode !== 2'd0) begin failures++; $display("FAIL reset_out_mode got=%0d exp=0", out_mode); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready got=%0b exp=1", in_ready); end
  endtask

  task automatic test_modes();
    logic [15:0] vimm [7];
    logic [1:0]  vmode [7];
    logic [31:0] vexp [7];
    vimm[0] = 16'h8004; vmode[0] = 2'b00; vexp[0] = 32'hFFFF8004;
    vimm[1] = 16'h8004; vmode[1] = 2'b01; vexp[1] = 32'h00008004;
    vimm[2] = 16'h8004; vmode[2] = 2'b10; vexp[2] = 32'h80040000;
    vimm[3] = 16'h8004; vmode[3] = 2'b11; vexp[3] = 32'hFFFE0010;
    vimm[4] = 16'hFFFF; vmode[4] = 2'b11; vexp[4] = 32'hFFFFFFFC;
    vimm[5] = 16'h7FFF; vmode[5] = 2'b11; vexp[5] = 32'h0001FFFC;
    vimm[6] = 16'h1234; vmode[6] = 2'b10; vexp[6] = 32'h12340000;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; imm = vimm[i]; mode = vmode[i];
      step();
      in_valid = 1'b0; imm = 16'hDEAD;
      checks++; if (out_valid !== 1'b1 || out_data !== vexp[i]) begin failures++; $display("FAIL mode_vec%0d_data got=%h vld=%0b exp=%h", i, out_data, out_valid, vexp[i]); end
      checks++; if (out_mode !== vmode[i]) begin failures++; $display("FAIL mode_vec%0d_tag got=%0d exp=%0d", i, out_mode, vmode[i]); end
      step();
    end
    for (int m = 0; m < 4; m++) begin
      in_valid = 1'b1; imm = 16'h0000; mode = 2'(m);
      step();
      in_valid = 1'b0;
      checks++; if (out_data !== 32'h0 || out_mode !== 2'(m)) begin failures++; $display("FAIL zero_imm_mode%0d got=%h/%0d exp=00000000/%0d", m, out_data, out_mode, m); end
      step();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h0001; mode = 2'b00;
    step();
    imm = 16'h0002; mode = 2'b01;
    step();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL bp_full_occ got=%0d exp=2", occupancy); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%0b exp=0", in_ready); end
    imm = 16'h0003; mode = 2'b10;
    step();
    checks++; if (occupancy !== 2'd2 || out_data !== 32'h1 || out_mode !== 2'b00) begin failures++; $display("FAIL bp_hold got occ=%0d data=%h mode=%0d exp occ=2 data=00000001 mode=0", occupancy, out_data, out_mode); end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_no_ready_path got=%0b exp=0", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_data !== 32'h2 || out_mode !== 2'b01 || occupancy !== 2'd1) begin failures++; $display("FAIL bp_drain_b got data=%h mode=%0d occ=%0d exp data=00000002 mode=1 occ=1", out_data, out_mode, occupancy); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_in_ready_after_pop got=%0b exp=1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h2) begin failures++; $display("FAIL bp_empty got vld=%0b occ=%0d data=%h exp vld=0 occ=0 data=00000002", out_valid, occupancy, out_data); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; imm = 16'(i); mode = 2'b00;
      step();
      checks++; if (out_data !== 32'(i) || occupancy !== 2'd1 || out_valid !== 1'b1) begin failures++; $display("FAIL stream_%0d got data=%h occ=%0d vld=%0b exp data=%h occ=1 vld=1", i, out_data, occupancy, out_valid, 32'(i)); end
    end
    in_valid = 1'b0;
    step();
    checks++; if (occupancy !== 2'd0) begin failures++; $display("FAIL stream_drain_occ got=%0d exp=0", occupancy); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid = 1'b1; imm = 16'h0005; mode = 2'b00;
    step();
    imm = 16'h0006;
    step();
    checks++; if (occupancy !== 2'd2) begin failures++; $display("FAIL rmid_fill got=%0d exp=2", occupancy); end
    rst = 1'b1; imm = 16'h0009; out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rmid_in_ready_during got=%0b exp=0", in_ready); end
    step();
    checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || out_mode !== 2'd0) begin failures++; $display("FAIL rmid_cleared got occ=%0d vld=%0b data=%h mode=%0d exp 0/0/0/0", occupancy, out_valid, out_data, out_mode); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL rmid_in_ready_after got=%0b exp=1", in_ready); end
  endtask

  task automatic test_narrow();
    logic [15:0] vexp [4];
    vexp[0] = 16'hFF80; vexp[1] = 16'h0080; vexp[2] = 16'h8000; vexp[3] = 16'hFE00;
    for (int m = 0; m < 4; m++) begin
      in_valid8 = 1'b1; imm8 = 8'h80; mode8 = 2'(m);
      step();
      in_valid8 = 1'b0;
      checks++; if (out_valid8 !== 1'b1 || out_data8 !== vexp[m] || out_mode8 !== 2'(m)) begin failures++; $display("FAIL narrow_mode%0d got=%h/%0d exp=%h/%0d", m, out_data8, out_mode8, vexp[m], m); end
      step();
    end
    checks++; if (occupancy8 !== 2'd0) begin failures++; $display("FAIL narrow_drain got=%0d exp=0", occupancy8); end
  endtask

  initial begin
    test_reset();
    test_modes();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_narrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised immediate-extension stage for the MIPS datapath. It extends an IN_W-bit instruction immediate to OUT_W bits in one of four modes: sign, zero, upper (LUI), and branch-offset (sign then <<2). Results pass through a 2-entry buffered valid/ready pipeline between decode and execute, so decode can keep issuing while execute stalls for one cycle.

Parameters:
IN_W, 16, immediate input width (>=2)
OUT_W, 32, extended output width; legal only if OUT_W >= IN_W+2
DEPTH, 2, buffer entries (fixed at 2; any other value is illegal)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  upstream presents imm/mode
in_ready  output  1  block can accept this cycle
imm  input  IN_W  raw immediate
mode  input  2  00 sign, 01 zero, 10 upper, 11 branch
out_valid  output  1  out_data holds a result
out_ready  input  1  downstream accepts out_data
out_data  output  OUT_W  extended result
out_mode  output  2  mode tag carried with result
occupancy  output  2  entries held (0..2)

Behaviour:
- Reset: one clock; reset is synchronous and active-high (clk, rst). Sampled at a clk edge with rst=1, the block clears both entries, occupancy=0, out_valid=0, out_data=0, out_mode=0. in_ready=0 while rst=1. Reset mid-transfer discards buffered data, and no handshake completes in that cycle.
- Extension (combinational, computed before storage):
  - sign: {(OUT_W-IN_W){imm[IN_W-1]}, imm}
  - zero: {(OUT_W-IN_W){1'b0}, imm}
  - upper: imm placed in bits [OUT_W-1 : OUT_W-IN_W], all lower bits 0
  - branch: the sign result shifted left by 2; the top 2 bits are dropped and bits [1:0]=0
- Push: accept when in_valid & in_ready at the edge. The extended value and mode are written to the tail entry.
- Pop: occurs when out_valid & out_ready at the edge. The head entry is removed.
- in_ready = ~rst & (occupancy != 2). This is combinational from registered state only and has no path from out_ready. Full therefore blocks push even if a pop happens in the same cycle.
- out_valid = (occupancy != 0). out_data and out_mode always show the head entry. When occupancy=0 they hold the last popped value (0 after reset).
- Latency: a push at edge N is visible on out_data after edge N when the buffer was empty. Throughput is 1 per cycle while out_ready=1.
- Simultaneous push and pop with occupancy=1: occupancy stays 1, the new entry becomes head, and order is preserved.
- Push with occupancy=2: cannot happen because in_ready=0. in_valid is ignored and nothing changes.
- Pop with occupancy=0: cannot happen because out_valid=0. out_ready is ignored.
- Ordering is strict FIFO. No entry is ever duplicated or dropped except by reset.
- Data held at the output is stable: while out_valid=1 & out_ready=0, out_data and out_mode do not change.
- Upstream protocol: imm and mode are sampled only on the accepting edge. The block does not rely on upstream holding them stable.
- Width rules: all arithmetic is unsigned bit manipulation. No overflow detection is performed.

Test Plan:
- Modes, IN_W=16/OUT_W=32, imm=16'h8004, out_ready=1: sign->32'hFFFF8004, zero->32'h00008004, upper->32'h80040000, branch->32'hFFFE0010; each appears 1 cycle after push with the matching out_mode.
- Branch edge cases: imm=16'hFFFF mode 11 -> 32'hFFFFFFFC; imm=16'h7FFF mode 11 -> 32'h0001FFFC; imm=16'h0000 all modes -> 32'h00000000.
- Backpressure: out_ready=0, push A=16'h0001(sign), then B=16'h0002(zero) -> occupancy=2, in_ready=0, a third push C is ignored. Raise out_ready -> A then B drain on consecutive cycles, in_ready=1 after the first pop, and C is never seen.
- Streaming: continuous in_valid with out_ready=1, 8 sequential immediates 0..7 sign mode -> outputs 0..7 in order, one per cycle, occupancy stays 1.
- Reset mid-operation: fill 2 entries, assert rst one cycle with in_valid=1 -> next cycle occupancy=0, out_valid=0, out_data=0, in_ready=0 during rst and 1 after.
- Parameter sweep IN_W=8/OUT_W=16: imm=8'h80 -> sign 16'hFF80, zero 16'h0080, upper 16'h8000, branch 16'hFE00.
